// File: rtl/sync_fifo_wr_arbiter_if.sv
// Bundle between NUM_REQ producers, the write arbiter and the FIFO write port.
// A beat moves on a rising edge where i_req_valid[r] and o_req_ready[r] are both high; valid never waits on ready.
interface sync_fifo_wr_arbiter_if #(
   parameter int WIDTH   = 16,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       i_req_valid;
   logic [NUM_REQ*WIDTH-1:0] i_req_data;
   logic [NUM_REQ-1:0]       o_req_ready;
   logic [WIDTH-1:0]         o_fifo_data;
   logic                     o_fifo_wr_en;
   logic                     i_fifo_full;
   logic [ID_W-1:0]          o_grant_id;
   logic                     o_busy;

   modport master (
      output i_req_valid, i_req_data, i_fifo_full,
      input  o_req_ready, o_fifo_data, o_fifo_wr_en, o_grant_id, o_busy
   );

   modport slave (
      input  i_req_valid, i_req_data, i_fifo_full,
      output o_req_ready, o_fifo_data, o_fifo_wr_en, o_grant_id, o_busy
   );
endinterface

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one sync_fifo write port among NUM_REQ producers.
// Each grant passes through IDLE, so a change of owner always costs one bubble cycle.
module sync_fifo_wr_arbiter #(
   parameter int WIDTH     = 16,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 8,
   localparam int ID_W     = $clog2(NUM_REQ),
   localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   sync_fifo_wr_arbiter_if.slave   bus,
   output logic                    dbg_state,
   output logic [CNT_W-1:0]        dbg_beat_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [ID_W:0]     rr_sum;
   logic [ID_W-1:0]   rr_cand;
   logic [ID_W-1:0]   pick_id;
   logic              pick_found;

   logic              in_burst;
   logic              grant_valid;
   logic              beat;
   logic              last_beat;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= ID_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Search last+1, last+2, ... with wrap; the first valid requester wins.
   always_comb begin
      rr_sum     = '0;
      rr_cand    = '0;
      pick_id    = '0;
      pick_found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         rr_sum = {1'b0, last_q} + (ID_W + 1)'(i);
         if (rr_sum >= (ID_W + 1)'(NUM_REQ)) begin
            rr_sum = rr_sum - (ID_W + 1)'(NUM_REQ);
         end
         rr_cand = rr_sum[ID_W-1:0];
         if (!pick_found && bus.i_req_valid[rr_cand]) begin
            pick_found = 1'b1;
            pick_id    = rr_cand;
         end
      end
   end

   assign in_burst    = (state_q == BURST);
   assign grant_valid = bus.i_req_valid[grant_q];
   assign beat        = in_burst && grant_valid && !bus.i_fifo_full;
   assign last_beat   = (cnt_q == CNT_W'(MAX_BURST - 1));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_id;
               last_d  = pick_id;
               cnt_d   = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            // A full FIFO freezes the burst: no beat, no count, no release.
            if (!bus.i_fifo_full) begin
               if (beat) begin
                  if (last_beat) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.o_req_ready  = (in_burst && !bus.i_fifo_full) ? (NUM_REQ'(1) << grant_q) : '0;
   assign bus.o_fifo_wr_en = beat;
   assign bus.o_fifo_data  = in_burst ? bus.i_req_data[int'(grant_q) * WIDTH +: WIDTH] : '0;
   assign bus.o_grant_id   = grant_q;
   assign bus.o_busy       = in_burst;

   assign dbg_state    = state_q;
   assign dbg_beat_cnt = cnt_q;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed bench for sync_fifo_wr_arbiter: producer models, FIFO-full control,
// scoreboard of expected FIFO writes and per-burst bookkeeping.
module tb_sync_fifo_wr_arbiter;
   localparam int WIDTH     = 16;
   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 8;
   localparam int CNT_W     = $clog2(MAX_BURST + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             dbg_state;
   logic [CNT_W-1:0] dbg_beat_cnt;

   sync_fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

   sync_fifo_wr_arbiter #(
      .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus.slave),
      .dbg_state(dbg_state),
      .dbg_beat_cnt(dbg_beat_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] exp_q[$];
   int len_q[$];
   int id_q[$];
   int gap_q[$];

   int base [NUM_REQ];
   int ptr  [NUM_REQ];
   int cnt  [NUM_REQ];

   logic               s_busy;
   logic               s_wr_en;
   logic [NUM_REQ-1:0] s_ready;
   logic [1:0]         s_grant;
   logic [CNT_W-1:0]   s_cnt;
   logic               prev_busy;
   int                 cur_len, cur_id, idle_len;
   bit                 seen_burst;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_producers();
      logic [NUM_REQ-1:0]       v;
      logic [NUM_REQ*WIDTH-1:0] d;
      v = '0;
      d = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         v[r] = (ptr[r] < cnt[r]);
         d[r*WIDTH +: WIDTH] = WIDTH'(base[r] + ptr[r]);
      end
      bus.i_req_valid = v;
      bus.i_req_data  = d;
   endtask

   task automatic arm(input int r, input int b, input int n);
      base[r] = b;
      ptr[r]  = 0;
      cnt[r]  = n;
      drive_producers();
   endtask

   task automatic push_exp(input int b, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(WIDTH'(b + i));
   endtask

   function automatic bit all_done();
      bit d;
      d = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) if (ptr[r] < cnt[r]) d = 1'b0;
      return d;
   endfunction

   // One clock: sample at negedge, score writes, then advance producers after the edge.
   task automatic step();
      logic [NUM_REQ-1:0] took;
      @(negedge clk);
      s_busy  = bus.o_busy;
      s_wr_en = bus.o_fifo_wr_en;
      s_ready = bus.o_req_ready;
      s_grant = bus.o_grant_id;
      s_cnt   = dbg_beat_cnt;
      chk("ready_onehot0", 32'($countones(s_ready) <= 1), 32'd1);
      if (s_wr_en) begin
         if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
         else chk("fifo_data", 32'(bus.o_fifo_data), 32'(exp_q.pop_front()));
      end
      if (s_busy) begin
         if (!prev_busy) begin
            if (seen_burst) gap_q.push_back(idle_len);
            cur_len    = 0;
            cur_id     = int'(s_grant);
            seen_burst = 1'b1;
         end
         if (s_wr_en) cur_len++;
      end else begin
         if (prev_busy) begin
            len_q.push_back(cur_len);
            id_q.push_back(cur_id);
            idle_len = 0;
         end
         idle_len++;
      end
      prev_busy = s_busy;
      took = bus.i_req_valid & s_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) if (took[r]) ptr[r]++;
      drive_producers();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(all_done() && !s_busy) && n < 300);
      chk({tag, "_drained"}, 32'(all_done() && !s_busy), 32'd1);
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_burst(input string tag, input int k, input int len, input int id);
      chk({tag, "_len"}, (k < len_q.size()) ? 32'(len_q[k]) : 32'hFFFF_FFFF, 32'(len));
      chk({tag, "_id"},  (k < id_q.size())  ? 32'(id_q[k])  : 32'hFFFF_FFFF, 32'(id));
   endtask

   task automatic chk_gap(input string tag, input int k);
      chk(tag, (k < gap_q.size()) ? 32'(gap_q[k]) : 32'hFFFF_FFFF, 32'd1);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
         base[r] = 0;
         ptr[r]  = 0;
         cnt[r]  = 0;
      end
      drive_producers();
      bus.i_fifo_full = 1'b0;
      exp_q.delete();
      len_q.delete();
      id_q.delete();
      gap_q.delete();
      prev_busy  = 1'b0;
      seen_burst = 1'b0;
      idle_len   = 0;
      cur_len    = 0;
      cur_id     = 0;
      #1;
      chk({tag, "_rst_busy"},  32'(bus.o_busy), 32'd0);
      chk({tag, "_rst_wr_en"}, 32'(bus.o_fifo_wr_en), 32'd0);
      chk({tag, "_rst_ready"}, 32'(bus.o_req_ready), 32'd0);
      chk({tag, "_rst_grant"}, 32'(bus.o_grant_id), 32'd0);
      chk({tag, "_rst_data"},  32'(bus.o_fifo_data), 32'd0);
      chk({tag, "_rst_cnt"},   32'(dbg_beat_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int n;

      // 1: single producer, 20 beats -> bursts 8,8,4 with one bubble between them
      do_reset("t1");
      arm(1, 16'h1000, 20);
      push_exp(16'h1000, 20);
      drain("t1");
      chk("t1_nbursts", 32'(len_q.size()), 32'd3);
      chk_burst("t1_b0", 0, 8, 1);
      chk_burst("t1_b1", 1, 8, 1);
      chk_burst("t1_b2", 2, 4, 1);
      chk_gap("t1_gap0", 0);
      chk_gap("t1_gap1", 1);

      // 2: all producers valid -> grant order 0,1,2,3,0 with full bursts
      do_reset("t2");
      arm(0, 16'h2000, 16);
      arm(1, 16'h2100, 8);
      arm(2, 16'h2200, 8);
      arm(3, 16'h2300, 8);
      push_exp(16'h2000, 8);
      push_exp(16'h2100, 8);
      push_exp(16'h2200, 8);
      push_exp(16'h2300, 8);
      push_exp(16'h2008, 8);
      drain("t2");
      chk("t2_nbursts", 32'(len_q.size()), 32'd5);
      chk_burst("t2_b0", 0, 8, 0);
      chk_burst("t2_b1", 1, 8, 1);
      chk_burst("t2_b2", 2, 8, 2);
      chk_burst("t2_b3", 3, 8, 3);
      chk_burst("t2_b4", 4, 8, 0);
      chk_gap("t2_gap3", 3);

      // 3: FIFO full for 5 cycles after beat 3 freezes the burst
      do_reset("t3");
      arm(2, 16'h3000, 8);
      push_exp(16'h3000, 8);
      n = 0;
      while (ptr[2] < 3 && n < 20) begin
         step();
         n++;
      end
      chk("t3_reach_beat3", 32'(ptr[2]), 32'd3);
      bus.i_fifo_full = 1'b1;
      repeat (5) begin
         step();
         chk("t3_full_wr_en", 32'(s_wr_en), 32'd0);
         chk("t3_full_cnt",   32'(s_cnt), 32'd3);
         chk("t3_full_busy",  32'(s_busy), 32'd1);
         chk("t3_full_ready", 32'(s_ready), 32'd0);
      end
      bus.i_fifo_full = 1'b0;
      drain("t3");
      chk("t3_nbursts", 32'(len_q.size()), 32'd1);
      chk_burst("t3_b0", 0, 8, 2);

      // 4: req0 drops after 2 beats, req3 takes over, then req0 ahead of req1
      do_reset("t4");
      arm(0, 16'h4000, 2);
      arm(3, 16'h4300, 8);
      push_exp(16'h4000, 2);
      push_exp(16'h4300, 8);
      push_exp(16'h4010, 4);
      push_exp(16'h4100, 4);
      n = 0;
      do begin
         step();
         n++;
      end while (!(s_busy && s_grant == 2'd3) && n < 20);
      chk("t4_reach_grant3", 32'(s_busy && s_grant == 2'd3), 32'd1);
      arm(0, 16'h4010, 4);
      arm(1, 16'h4100, 4);
      drain("t4");
      chk("t4_nbursts", 32'(len_q.size()), 32'd4);
      chk_burst("t4_b0", 0, 2, 0);
      chk_burst("t4_b1", 1, 8, 3);
      chk_burst("t4_b2", 2, 4, 0);
      chk_burst("t4_b3", 3, 4, 1);
      chk_gap("t4_gap0", 0);

      // 5: asynchronous reset between edges mid-burst
      do_reset("t5");
      arm(1, 16'h5000, 8);
      push_exp(16'h5000, 8);
      n = 0;
      while (ptr[1] < 3 && n < 20) begin
         step();
         n++;
      end
      chk("t5_reach_beat3", 32'(ptr[1]), 32'd3);
      #2;
      chk("t5_pre_wr_en", 32'(bus.o_fifo_wr_en), 32'd1);
      chk("t5_pre_ready", 32'(bus.o_req_ready), 32'b0010);
      rst = 1'b1;
      #1;
      chk("t5_async_wr_en", 32'(bus.o_fifo_wr_en), 32'd0);
      chk("t5_async_ready", 32'(bus.o_req_ready), 32'd0);
      chk("t5_async_busy",  32'(bus.o_busy), 32'd0);
      chk("t5_async_grant", 32'(bus.o_grant_id), 32'd0);
      do_reset("t5r");
      arm(0, 16'h5100, 2);
      arm(1, 16'h5200, 2);
      push_exp(16'h5100, 2);
      push_exp(16'h5200, 2);
      drain("t5r");
      chk("t5_nbursts", 32'(len_q.size()), 32'd2);
      chk_burst("t5_b0", 0, 2, 0);
      chk_burst("t5_b1", 1, 2, 1);

      // 6: no requests -> stays idle
      do_reset("t6");
      repeat (10) begin
         step();
         chk("t6_busy",  32'(s_busy), 32'd0);
         chk("t6_wr_en", 32'(s_wr_en), 32'd0);
         chk("t6_ready", 32'(s_ready), 32'd0);
         chk("t6_state", 32'(dbg_state), 32'd0);
      end
      chk("t6_nbursts", 32'(len_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
